count_sequencer: RTL and testbench
==================================

# count_sequencer

Controller for the 4-bit up/down display counter. It turns push-button inputs (start, stop, single step, direction) into one-cycle enable pulses and a direction bit for the counter state register. It keeps a shadow copy of the count so it can report the terminal value. It sits between the board buttons and the state-machine/register pair that feeds the 7-segment decoder.

## Interface
Parameters:
- `PRESCALE`, default 4: clock cycles between automatic steps in RUN. Legal range is 1..255.
- `MAX_COUNT`, default 9: the count range is 0..MAX_COUNT. Legal range is 1..15.

Ports:
- `clock`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: level input; its rising edge requests RUN.
- `stop`  in  1: level input; its rising edge requests IDLE.
- `step`  in  1: level input; its rising edge requests one manual step, honoured in IDLE only.
- `down`  in  1: direction; 1 = decrement.
- `step_en`  out  1: registered one-cycle pulse; drives the register enable.
- `step_down`  out  1: registered direction that accompanies `step_en`.
- `count`  out  4: shadow count; matches the downstream register.
- `terminal`  out  1: 1 when `count` is at the limit for the current `down` (MAX_COUNT going up, 0 going down).
- `running`  out  1: 1 while in RUN.

## Operation
- Edge detection:
  - Each of start, stop and step has a previous-sample flop.
  - rise = in & ~prev.
  - The prev flops reset to 1, so an input held high through reset does not produce an edge.
- FSM states:
  - IDLE → RUN on start rise; the prescaler is cleared to 0.
  - RUN → IDLE on stop rise.
  - Start rise while in RUN is ignored.
- Priority at the same edge: stop > start > step.
  - Start and step together in IDLE: enter RUN, no manual pulse.
- Manual step: a step rise in IDLE sets `step_en`=1 for exactly one cycle. A step rise in RUN is ignored.
- RUN prescaler:
  - If prescaler == PRESCALE-1: prescaler ← 0 and `step_en` ← 1.
  - Otherwise: prescaler+1 and `step_en` ← 0.
  - A stop rise on the terminal edge suppresses that pulse.
- Direction: `step_down` ← `down`, sampled at the same edge that sets `step_en`. A direction change mid-run takes effect on the next pulse.
- Shadow count update, at each edge where `step_en`=1:
  - Up: MAX_COUNT wraps to 0.
  - Down: 0 wraps to MAX_COUNT.
  - Otherwise ±1.
- `terminal` is combinational from `count` and `down`.
- Reset values:
  - State IDLE, prescaler 0, `count` 0.
  - `step_en`, `step_down` and `running` all 0.
  - Edge flops 1.
- Reset mid-run: everything returns to the reset values at that edge, and any pending pulse is dropped.

## Timing
- Manual step: rise sampled at edge k → `step_en` high between edges k and k+1 → `count` updates at edge k+1.
- Start rise at edge k: `running` is 1 after edge k. The first `step_en` goes high after edge k+PRESCALE; the pulse period is PRESCALE cycles.
- PRESCALE=1 holds `step_en` continuously high in RUN.
- Stop rise at edge k: `running` is 0 after edge k and `step_en` is 0 after edge k.

## Configuration
- `COUNT_SEQ_LIMIT_STOP_EN` defined:
  - In RUN, at the edge where `count` updates onto the terminal value for the current direction, the FSM goes to IDLE and `running` drops at that same edge.
  - Manual steps still wrap.
- Macro undefined: RUN wraps and continues indefinitely.

## Structure
- Package `count_seq_pkg` holds:
  - the FSM state enum (IDLE, RUN);
  - COUNT_W = 4;
  - the default PRESCALE and MAX_COUNT values.
- Sub-module `rise_detect` (one flop plus AND, parameterised reset value) is instantiated three times.

## Test plan
- Reset with `step` held high, then keep it high → no `step_en`; `count`=0, `running`=0.
- IDLE, `down`=0, three step rises with MAX_COUNT=9 from count 8 → counts 9, 0, 1; `terminal`=1 only at 9.
- Start rise at edge k, PRESCALE=4 → `step_en` after edges k+4, k+8, k+12; toggle `down` before edge k+8 → `step_down`=1 on the second pulse.
- Start and stop rise on the same edge in IDLE → stays IDLE, no pulse. Stop rise on the prescaler-terminal edge → no pulse, `running`=0.
- Reset asserted mid-RUN with count 5 → next cycle `count`=0, `step_en`=0, IDLE.
- With `COUNT_SEQ_LIMIT_STOP_EN`, RUN from 7 upward, MAX_COUNT=9 → steps to 8, 9, then `running`=0 and `count` stays 9. Without the macro → continues 0, 1, …

Source files
------------

// File: rtl/count_seq_pkg.sv
// Shared types and defaults for the count sequencer.
// Optional build macro: COUNT_SEQ_LIMIT_STOP_EN.
package count_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int COUNT_W       = 4;
    localparam int DEF_PRESCALE  = 4;
    localparam int DEF_MAX_COUNT = 9;

    function automatic logic [COUNT_W-1:0] next_count(
        input logic [COUNT_W-1:0] cur,
        input logic               dn,
        input logic [COUNT_W-1:0] maxc
    );
        logic [COUNT_W-1:0] res;
        if (dn) res = (cur == '0) ? maxc : cur - 1'b1;
        else    res = (cur == maxc) ? '0 : cur + 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/count_sequencer_rise_detect.sv
// Rising-edge detector: one previous-sample flop plus AND.
// Reset value of the flop is a parameter so held inputs give no edge.
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic in_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clock) begin
        if (reset) prev_q <= RST_VAL;
        else       prev_q <= in_i;
    end

    assign rise_o = in_i & ~prev_q;

endmodule

// File: rtl/count_sequencer.sv
// Button-to-pulse sequencer for the 4-bit up/down display counter.
// Optional build macro: COUNT_SEQ_LIMIT_STOP_EN (stop RUN at the limit).
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int PRESCALE  = DEF_PRESCALE,
    parameter int MAX_COUNT = DEF_MAX_COUNT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               step,
    input  logic               down,
    output logic               step_en,
    output logic               step_down,
    output logic [COUNT_W-1:0] count,
    output logic               terminal,
    output logic               running
);

    localparam logic [COUNT_W-1:0] MAX_C    = COUNT_W'(MAX_COUNT);
    localparam logic [COUNT_W-1:0] ZERO_C   = '0;
    localparam logic [7:0]         PRE_LAST = 8'(PRESCALE - 1);

    state_e             state_q;
    logic [7:0]         presc_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               step_en_q;
    logic               step_down_q;
    logic               running_q;
    logic               start_rise;
    logic               stop_rise;
    logic               step_rise;
    logic               limit_hit;

    rise_detect #(.RST_VAL(1'b1)) u_start (
        .clock(clock), .reset(reset), .in_i(start), .rise_o(start_rise)
    );
    rise_detect #(.RST_VAL(1'b1)) u_stop (
        .clock(clock), .reset(reset), .in_i(stop), .rise_o(stop_rise)
    );
    rise_detect #(.RST_VAL(1'b1)) u_step (
        .clock(clock), .reset(reset), .in_i(step), .rise_o(step_rise)
    );

    always_comb begin
        count_d   = next_count(count_q, step_down_q, MAX_C);
        limit_hit = step_en_q &&
                    (count_d == (step_down_q ? ZERO_C : MAX_C));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            count_q     <= '0;
            step_en_q   <= 1'b0;
            step_down_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            if (step_en_q) count_q <= count_d;
            step_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // stop beats start beats step on a shared edge
                    if (!stop_rise && start_rise) begin
                        state_q   <= RUN;
                        presc_q   <= '0;
                        running_q <= 1'b1;
                    end else if (!stop_rise && step_rise) begin
                        step_en_q   <= 1'b1;
                        step_down_q <= down;
                    end
                end
                RUN: begin
                    if (stop_rise) begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end
`ifdef COUNT_SEQ_LIMIT_STOP_EN
                    else if (limit_hit) begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end
`endif
                    else if (presc_q == PRE_LAST) begin
                        presc_q     <= '0;
                        step_en_q   <= 1'b1;
                        step_down_q <= down;
                    end else begin
                        presc_q <= presc_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign step_en   = step_en_q;
    assign step_down = step_down_q;
    assign count     = count_q;
    assign running   = running_q;
    assign terminal  = down ? (count_q == ZERO_C) : (count_q == MAX_C);

endmodule

// File: tb/tb_count_sequencer.sv
// Directed-vector bench for count_sequencer (PRESCALE=4, MAX_COUNT=9).
// Honours COUNT_SEQ_LIMIT_STOP_EN when the build defines it.
module tb_count_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       step;
    logic       down;
    logic       step_en;
    logic       step_down;
    logic [3:0] count;
    logic       terminal;
    logic       running;

    int checks = 0;
    int errors = 0;

`ifdef COUNT_SEQ_LIMIT_STOP_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    count_sequencer #(.PRESCALE(4), .MAX_COUNT(9)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .step     (step),
        .down     (down),
        .step_en  (step_en),
        .step_down(step_down),
        .count    (count),
        .terminal (terminal),
        .running  (running)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit st;
        bit sp;
        bit sx;
        bit dn;
        bit en;
        bit sd;
        int cnt;
        bit tm;
        bit rn;
    } vec_t;

    vec_t tbl[32];

    function automatic vec_t v(input bit st, input bit sp, input bit sx,
                               input bit dn, input bit en, input bit sd,
                               input int cnt, input bit tm, input bit rn);
        vec_t r;
        r.st = st; r.sp = sp; r.sx = sx; r.dn = dn;
        r.en = en; r.sd = sd; r.cnt = cnt; r.tm = tm; r.rn = rn;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic man_step(input bit dn);
        down = dn;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
    endtask

    initial begin
        // st sp sx dn | en sd cnt tm rn  (outputs after the edge)
        tbl[0]  = v(0,0,1,0, 0,0,0,0,0);
        tbl[1]  = v(0,0,0,1, 0,0,0,1,0);
        tbl[2]  = v(0,0,1,1, 1,1,0,1,0);
        tbl[3]  = v(0,0,0,1, 0,1,9,0,0);
        tbl[4]  = v(0,0,1,1, 1,1,9,0,0);
        tbl[5]  = v(0,0,0,0, 0,1,8,0,0);
        tbl[6]  = v(0,0,1,0, 1,0,8,0,0);
        tbl[7]  = v(0,0,0,0, 0,0,9,1,0);
        tbl[8]  = v(0,0,1,0, 1,0,9,1,0);
        tbl[9]  = v(0,0,0,0, 0,0,0,0,0);
        tbl[10] = v(0,0,1,0, 1,0,0,0,0);
        tbl[11] = v(0,0,0,0, 0,0,1,0,0);
        tbl[12] = v(1,1,0,0, 0,0,1,0,0);
        tbl[13] = v(0,0,0,0, 0,0,1,0,0);
        tbl[14] = v(1,0,1,0, 0,0,1,0,1);
        tbl[15] = v(1,0,0,0, 0,0,1,0,1);
        tbl[16] = v(0,0,1,0, 0,0,1,0,1);
        tbl[17] = v(0,0,0,0, 0,0,1,0,1);
        tbl[18] = v(0,0,0,0, 1,0,1,0,1);
        tbl[19] = v(0,0,0,0, 0,0,2,0,1);
        tbl[20] = v(0,0,0,0, 0,0,2,0,1);
        tbl[21] = v(0,0,0,1, 0,0,2,0,1);
        tbl[22] = v(0,0,0,1, 1,1,2,0,1);
        tbl[23] = v(0,0,0,1, 0,1,1,0,1);
        tbl[24] = v(0,0,0,0, 0,1,1,0,1);
        tbl[25] = v(0,0,0,0, 0,1,1,0,1);
        tbl[26] = v(0,0,0,0, 1,0,1,0,1);
        tbl[27] = v(0,0,0,0, 0,0,2,0,1);
        tbl[28] = v(0,0,0,0, 0,0,2,0,1);
        tbl[29] = v(0,0,0,0, 0,0,2,0,1);
        tbl[30] = v(0,1,0,0, 0,0,2,0,0);
        tbl[31] = v(0,0,0,0, 0,0,2,0,0);

        reset = 1'b1; start = 1'b0; stop = 1'b0;
        step = 1'b1; down = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst step_en", int'(step_en), 0);
        chk("rst count", int'(count), 0);
        chk("rst running", int'(running), 0);
        chk("rst step_down", int'(step_down), 0);

        for (int i = 0; i < 32; i++) begin
            start = tbl[i].st;
            stop  = tbl[i].sp;
            step  = tbl[i].sx;
            down  = tbl[i].dn;
            tick();
            chk($sformatf("row%0d step_en", i), int'(step_en), int'(tbl[i].en));
            chk($sformatf("row%0d step_down", i), int'(step_down), int'(tbl[i].sd));
            chk($sformatf("row%0d count", i), int'(count), tbl[i].cnt);
            chk($sformatf("row%0d terminal", i), int'(terminal), int'(tbl[i].tm));
            chk($sformatf("row%0d running", i), int'(running), int'(tbl[i].rn));
        end

        // reset mid-run at the edge that would raise a pulse, count 5
        repeat (3) man_step(1'b0);
        chk("pre-run count", int'(count), 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("mid-run running", int'(running), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst-run count", int'(count), 0);
        chk("rst-run step_en", int'(step_en), 0);
        chk("rst-run running", int'(running), 0);
        tick();
        chk("rst-run drop step_en", int'(step_en), 0);
        chk("rst-run drop count", int'(count), 0);

        // run upward from 7 towards the limit
        repeat (7) man_step(1'b0);
        chk("lim pre count", int'(count), 7);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("lim count k+5", int'(count), 8);
        repeat (4) tick();
        chk("lim count k+9", int'(count), 9);
        chk("lim running k+9", int'(running), LIMIT ? 0 : 1);
        repeat (4) tick();
        chk("lim count k+13", int'(count), LIMIT ? 9 : 0);
        repeat (4) tick();
        chk("lim count k+17", int'(count), LIMIT ? 9 : 1);
        chk("lim running k+17", int'(running), LIMIT ? 0 : 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
